sdram_arbit: RTL and testbench

- Central scheduler between the SDRAM sub-controllers (init, auto-refresh, write burst, read burst) and the SDRAM command/address pins.
- Owns the auto-refresh interval timer and latches the one-cycle write/read triggers from the UART command decoder.
- Grants the SDRAM to exactly one sub-controller at a time and muxes that sub-controller's command, address and bank onto the pins.

---
 rtl/sdram_arbit.sv | 150 +++++++++++++++
 tb/tb_sdram_arbit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbit.sv
// SDRAM command scheduler: owns the auto-refresh timer, latches write/read triggers
// and grants the pins to exactly one sub-controller (init, refresh, write, read).
module sdram_arbit #(
  parameter int REF_CNT   = 780,
  parameter int REF_CNT_W = 10
) (
  input  logic        s_clk,
  input  logic        s_rst,
  input  logic        init_done,
  input  logic [3:0]  init_cmd,
  input  logic [11:0] init_addr,
  input  logic        wr_trig,
  input  logic        rd_trig,
  input  logic [3:0]  ref_cmd,
  input  logic        ref_end,
  input  logic [3:0]  wr_cmd,
  input  logic [11:0] wr_addr,
  input  logic [1:0]  wr_baddr,
  input  logic        wr_end,
  input  logic [3:0]  rd_cmd,
  input  logic [11:0] rd_addr,
  input  logic [1:0]  rd_baddr,
  input  logic        rd_end,
  output logic        ref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic        ref_req,
  output logic [3:0]  sdram_cmd,
  output logic [11:0] sdram_addr,
  output logic [1:0]  sdram_baddr,
  output logic        busy,
  output logic        ref_overrun
);

  typedef enum logic [2:0] {
    S_INIT,
    S_ARBIT,
    S_AREF,
    S_WRITE,
    S_READ
  } state_e;

  localparam logic [3:0]           CMD_NOP  = 4'b0111;
  localparam logic [REF_CNT_W-1:0] REF_LAST = REF_CNT_W'(REF_CNT - 1);

  state_e               state_q, state_d;
  logic [REF_CNT_W-1:0] ref_cnt_q, ref_cnt_d;
  logic                 ref_req_q, ref_req_d;
  logic                 ref_ovr_q, ref_ovr_d;
  logic                 wr_pend_q, wr_pend_d;
  logic                 rd_pend_q, rd_pend_d;
  logic                 ref_en_q, wr_en_q, rd_en_q;
  logic                 grant_ref, grant_wr, grant_rd;
  logic                 ref_expire;

  // Fixed priority: refresh beats write beats read, decided only while idle.
  assign grant_ref = (state_q == S_ARBIT) && ref_req_q;
  assign grant_wr  = (state_q == S_ARBIT) && !ref_req_q && wr_pend_q;
  assign grant_rd  = (state_q == S_ARBIT) && !ref_req_q && !wr_pend_q && rd_pend_q;

  assign ref_expire = init_done && (ref_cnt_q == REF_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge s_clk) begin
    if (s_rst) state_q <= S_INIT;
    else       state_q <= state_d;
  end

  // NOTE: defaulting every combinational output first guarantees no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT:  if (init_done) state_d = S_ARBIT;
      S_ARBIT: begin
        if      (grant_ref) state_d = S_AREF;
        else if (grant_wr)  state_d = S_WRITE;
        else if (grant_rd)  state_d = S_READ;
      end
      S_AREF:  if (ref_end) state_d = S_ARBIT;
      S_WRITE: if (wr_end)  state_d = S_ARBIT;
      S_READ:  if (rd_end)  state_d = S_ARBIT;
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    sdram_cmd   = CMD_NOP;
    sdram_addr  = '0;
    sdram_baddr = '0;
    case (state_q)
      S_INIT: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
      S_AREF:  sdram_cmd = ref_cmd;
      S_WRITE: begin
        sdram_cmd   = wr_cmd;
        sdram_addr  = wr_addr;
        sdram_baddr = wr_baddr;
      end
      S_READ: begin
        sdram_cmd   = rd_cmd;
        sdram_addr  = rd_addr;
        sdram_baddr = rd_baddr;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != S_ARBIT);

  // A new request (timer expiry or trigger) wins over the clear from a same-cycle grant.
  always_comb begin
    ref_cnt_d = '0;
    if (init_done) ref_cnt_d = ref_expire ? '0 : ref_cnt_q + REF_CNT_W'(1);
    ref_req_d = ref_expire | (ref_req_q & ~grant_ref);
    ref_ovr_d = ref_ovr_q | (ref_expire & ref_req_q & ~grant_ref);
    wr_pend_d = wr_trig | (wr_pend_q & ~grant_wr);
    rd_pend_d = rd_trig | (rd_pend_q & ~grant_rd);
  end

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      ref_cnt_q <= '0;
      ref_req_q <= 1'b0;
      ref_ovr_q <= 1'b0;
      wr_pend_q <= 1'b0;
      rd_pend_q <= 1'b0;
      ref_en_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
    end else begin
      ref_cnt_q <= ref_cnt_d;
      ref_req_q <= ref_req_d;
      ref_ovr_q <= ref_ovr_d;
      wr_pend_q <= wr_pend_d;
      rd_pend_q <= rd_pend_d;
      ref_en_q  <= grant_ref;
      wr_en_q   <= grant_wr;
      rd_en_q   <= grant_rd;
    end
  end

  assign ref_en      = ref_en_q;
  assign wr_en       = wr_en_q;
  assign rd_en       = rd_en_q;
  assign ref_req     = ref_req_q;
  assign ref_overrun = ref_ovr_q;

endmodule

// File: tb/tb_sdram_arbit.sv
// Randomized bench for sdram_arbit against a transaction-level reference model
// (owner of the pins, pending flags, refresh due times from elapsed cycles).
module tb_sdram_arbit;

  localparam int REF_CNT = 20;

  logic        s_clk, s_rst, init_done;
  logic [3:0]  init_cmd, ref_cmd, wr_cmd, rd_cmd;
  logic [11:0] init_addr, wr_addr, rd_addr;
  logic [1:0]  wr_baddr, rd_baddr;
  logic        wr_trig, rd_trig, ref_end, wr_end, rd_end;
  logic        ref_en, wr_en, rd_en, ref_req, busy, ref_overrun;
  logic [3:0]  sdram_cmd;
  logic [11:0] sdram_addr;
  logic [1:0]  sdram_baddr;

  sdram_arbit #(.REF_CNT(REF_CNT), .REF_CNT_W(5)) dut (
    .s_clk(s_clk), .s_rst(s_rst), .init_done(init_done),
    .init_cmd(init_cmd), .init_addr(init_addr),
    .wr_trig(wr_trig), .rd_trig(rd_trig),
    .ref_cmd(ref_cmd), .ref_end(ref_end),
    .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_baddr(wr_baddr), .wr_end(wr_end),
    .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_baddr(rd_baddr), .rd_end(rd_end),
    .ref_en(ref_en), .wr_en(wr_en), .rd_en(rd_en), .ref_req(ref_req),
    .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_baddr(sdram_baddr),
    .busy(busy), .ref_overrun(ref_overrun)
  );

  initial s_clk = 1'b0;
  always #10 s_clk = ~s_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: who owns the pins, what is pending, and how long init_done has been high.
  typedef enum {M_INIT, M_ARB, M_REF, M_WR, M_RD} own_e;
  own_e m_owner = M_INIT;
  int   m_age = 0, m_k = 0;
  bit   m_req, m_ovr, m_wp, m_rp, m_ref_en, m_wr_en, m_rd_en;

  int dur_ref = 3, dur_wr = 3, dur_rd = 3;
  bit rnd = 0;

  task automatic model_step();
    own_e nxt;
    bit g_ref, g_wr, g_rd, due;
    if (s_rst) begin
      m_owner = M_INIT; m_age = 0; m_k = 0;
      {m_req, m_ovr, m_wp, m_rp, m_ref_en, m_wr_en, m_rd_en} = '0;
    end else begin
      g_ref = (m_owner == M_ARB) && m_req;
      g_wr  = (m_owner == M_ARB) && !m_req && m_wp;
      g_rd  = (m_owner == M_ARB) && !m_req && !m_wp && m_rp;
      due   = init_done && ((m_k % REF_CNT) == REF_CNT - 1);
      m_ovr = m_ovr || (due && m_req && !g_ref);
      m_req = due || (m_req && !g_ref);
      m_wp  = wr_trig || (m_wp && !g_wr);
      m_rp  = rd_trig || (m_rp && !g_rd);
      m_ref_en = g_ref; m_wr_en = g_wr; m_rd_en = g_rd;
      nxt = m_owner;
      case (m_owner)
        M_INIT: if (init_done) nxt = M_ARB;
        M_ARB:  nxt = g_ref ? M_REF : g_wr ? M_WR : g_rd ? M_RD : M_ARB;
        M_REF:  if (ref_end) nxt = M_ARB;
        M_WR:   if (wr_end)  nxt = M_ARB;
        default: if (rd_end) nxt = M_ARB;
      endcase
      m_age   = (nxt == m_owner) ? m_age + 1 : 0;
      m_owner = nxt;
      m_k     = init_done ? m_k + 1 : 0;
    end
  endtask

  task automatic compare_all();
    logic [3:0]  ec;
    logic [11:0] ea;
    logic [1:0]  eb;
    ec = 4'b0111; ea = '0; eb = '0;
    case (m_owner)
      M_INIT: begin ec = init_cmd; ea = init_addr; end
      M_REF:  ec = ref_cmd;
      M_WR:   begin ec = wr_cmd; ea = wr_addr; eb = wr_baddr; end
      M_RD:   begin ec = rd_cmd; ea = rd_addr; eb = rd_baddr; end
      default: ;
    endcase
    check("ref_en", 32'(ref_en), 32'(m_ref_en));
    check("wr_en", 32'(wr_en), 32'(m_wr_en));
    check("rd_en", 32'(rd_en), 32'(m_rd_en));
    check("ref_req", 32'(ref_req), 32'(m_req));
    check("ref_overrun", 32'(ref_overrun), 32'(m_ovr));
    check("busy", 32'(busy), 32'(m_owner != M_ARB));
    check("sdram_cmd", 32'(sdram_cmd), 32'(ec));
    check("sdram_addr", 32'(sdram_addr), 32'(ea));
    check("sdram_baddr", 32'(sdram_baddr), 32'(eb));
  endtask

  // Sub-controllers finish their operation after a programmable number of cycles.
  task automatic drive_subs();
    ref_end   = (m_owner == M_REF && m_age >= dur_ref) || (rnd && $urandom_range(0, 15) == 0);
    wr_end    = (m_owner == M_WR  && m_age >= dur_wr)  || (rnd && $urandom_range(0, 15) == 0);
    rd_end    = (m_owner == M_RD  && m_age >= dur_rd)  || (rnd && $urandom_range(0, 15) == 0);
    ref_cmd   = 4'($urandom);
    wr_cmd    = 4'($urandom);
    rd_cmd    = 4'($urandom);
    wr_addr   = 12'($urandom);
    rd_addr   = 12'($urandom);
    wr_baddr  = 2'($urandom);
    rd_baddr  = 2'($urandom);
    init_addr = 12'($urandom);
  endtask

  task automatic cyc();
    drive_subs();
    @(posedge s_clk);
    model_step();
    @(negedge s_clk);
    compare_all();
  endtask

  task automatic pulse(input bit w, input bit r);
    wr_trig = w; rd_trig = r;
    cyc();
    wr_trig = 1'b0; rd_trig = 1'b0;
  endtask

  // sel: 0 idle, 1 ref_en, 2 wr_en, 3 rd_en, 4 wr_en|rd_en, 5 ref_req
  task automatic wait_for(input string tag, input int sel, input int limit, output int n);
    bit hit;
    hit = 1'b0; n = 0;
    while (!hit && n < limit) begin
      cyc(); n++;
      case (sel)
        0: hit = !busy;
        1: hit = ref_en;
        2: hit = wr_en;
        3: hit = rd_en;
        4: hit = wr_en || rd_en;
        default: hit = ref_req;
      endcase
    end
    check(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    int n, cnt, hold;
    s_rst = 1'b1; init_done = 1'b0; init_cmd = 4'b0010;
    wr_trig = 1'b0; rd_trig = 1'b0;
    repeat (2) cyc();
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_en", 32'({ref_en, wr_en, rd_en}), 32'd0);
    check("rst_req_ovr", 32'({ref_req, ref_overrun}), 32'd0);

    // 1: init pass-through, first refresh 20 cycles after init_done
    s_rst = 1'b0;
    repeat (8) cyc();
    check("t1_init_cmd", 32'(sdram_cmd), 32'h2);
    init_done = 1'b1;
    cyc();
    check("t1_arbit", 32'(busy), 32'd0);
    check("t1_nop", 32'(sdram_cmd), 32'h7);
    wait_for("t1_req_seen", 5, 40, n);
    check("t1_req_delay", 32'(n + 1), 32'd20);

    // 2: write trigger alongside refresh request: refresh first, then write
    pulse(1'b1, 1'b0);
    check("t2_ref_first", 32'({ref_en, wr_en}), 32'b10);
    check("t2_req_clr", 32'(ref_req), 32'd0);
    wait_for("t2_wr_seen", 2, 30, n);
    check("t2_gap", 32'(n), 32'(dur_ref + 2));
    check("t2_mux_cmd", 32'(sdram_cmd), 32'(wr_cmd));
    check("t2_mux_addr", 32'({sdram_baddr, sdram_addr}), 32'({wr_baddr, wr_addr}));

    // 3: simultaneous triggers, extra read trigger during write
    wait_for("t3_idle", 0, 30, n);
    pulse(1'b1, 1'b1);
    wait_for("t3_grant", 4, 30, n);
    check("t3_wr_first", 32'(wr_en), 32'd1);
    pulse(1'b0, 1'b1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (rd_en) cnt++;
    end
    check("t3_rd_once", 32'(cnt), 32'd1);

    // 4: refresh held long enough for two expiries
    dur_ref = 45;
    wait_for("t4_ref_grant", 1, 60, n);
    wait_for("t4_back_idle", 0, 60, n);
    check("t4_overrun", 32'(ref_overrun), 32'd1);
    check("t4_req_again", 32'(ref_req), 32'd1);
    cyc();
    check("t4_regrant", 32'(ref_en), 32'd1);
    dur_ref = 3;
    repeat (10) cyc();
    check("t4_sticky", 32'(ref_overrun), 32'd1);

    // 5: reset during a write with a read pending
    dur_wr = 10;
    wait_for("t5_idle", 0, 40, n);
    pulse(1'b1, 1'b1);
    wait_for("t5_wr_grant", 2, 30, n);
    repeat (2) cyc();
    s_rst = 1'b1; init_done = 1'b0;
    cyc();
    s_rst = 1'b0;
    check("t5_busy", 32'(busy), 32'd1);
    check("t5_flags", 32'({ref_en, wr_en, rd_en, ref_req, ref_overrun}), 32'd0);
    check("t5_init_cmd", 32'(sdram_cmd), 32'h2);
    repeat (3) cyc();
    init_done = 1'b1;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      if (rd_en || wr_en) cnt++;
    end
    check("t5_no_stale", 32'(cnt), 32'd0);
    pulse(1'b0, 1'b1);
    wait_for("t5_rd_after_trig", 3, 30, n);
    dur_wr = 3;

    // 6: read trigger on the cycle its own grant is decided
    pulse(1'b0, 1'b1);
    n = 0;
    while (!(m_owner == M_ARB && m_rp && !m_req && !m_wp) && n < 30) begin
      cyc(); n++;
    end
    check("t6_sync", 32'(n < 30), 32'd1);
    pulse(1'b0, 1'b1);
    check("t6_first", 32'(rd_en), 32'd1);
    wait_for("t6_second", 3, 40, n);

    // Random traffic with spurious end pulses and occasional resets
    rnd = 1'b1; hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 64 == 0) begin
        dur_ref = $urandom_range(0, 50);
        dur_wr  = $urandom_range(0, 12);
        dur_rd  = $urandom_range(0, 12);
      end
      wr_trig = ($urandom_range(0, 9) == 0);
      rd_trig = ($urandom_range(0, 9) == 0);
      s_rst   = ($urandom_range(0, 299) == 0);
      if (s_rst) hold = $urandom_range(1, 6);
      init_done = (hold == 0);
      cyc();
      if (!s_rst && hold > 0) hold--;
    end
    s_rst = 1'b0; wr_trig = 1'b0; rd_trig = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
